// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial A - B - BIN, LSB first, one bit per clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);

    localparam int                 CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               c_q, c_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_bit;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_res_shift;

    assign w_bit       = a_q[0] ^ b_q[0] ^ c_q;
    assign w_borrow    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & c_q);
    assign w_res_shift = {w_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        bout_d  = bout_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = BIN;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d = w_res_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = w_borrow;
                cnt_d = cnt_q + CNT_ONE;
                // Visible result only updates here, so D never shows a partial word.
                if (cnt_q == CNT_LAST) begin
                    dout_d  = w_res_shift;
                    bout_d  = w_borrow;
                    state_d = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
        end
    end

    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_FIN);
    assign D    = dout_q;
    assign BOUT = bout_q;

endmodule

`default_nettype wire
